// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the animated sprite renderer.
package sprite_pkg;

  localparam int COORD_W  = 10;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } anim_state_t;

  typedef enum logic {
    LOOP    = 1'b0,
    ONESHOT = 1'b1
  } anim_mode_t;

endpackage

// File: rtl/sprite_anim_seq.sv
// Animation sequencer: steps through sprite-sheet frames, holding each for
// HOLD_TICKS video frames, in loop or one-shot mode.
module sprite_anim_seq
  import sprite_pkg::*;
#(
  parameter int FRAMES     = 4,
  parameter int HOLD_TICKS = 8,
  localparam int FR_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  input  logic            frame_start,
  input  logic            anim_start,
  input  logic            anim_mode,
  output logic [FR_W-1:0] anim_frame,
  output logic            anim_busy,
  output logic            anim_done,
  output logic [1:0]      anim_state
);

  localparam int CNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(FRAMES - 1);

  anim_state_t      state_q, state_d;
  anim_mode_t       mode_q, mode_d;
  logic [FR_W-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= LOOP;
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  // anim_start restarts from any state and swallows a coincident frame_start.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    if (anim_start) begin
      state_d = PLAY;
      mode_d  = anim_mode_t'(anim_mode);
      frame_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_d = '0;
          cnt_d   = '0;
        end
        PLAY: begin
          if (frame_start) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              if (frame_q == FRAME_LAST) begin
                if (mode_q == ONESHOT) state_d = DONE;
                else                   frame_d = '0;
              end else begin
                frame_d = frame_q + 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    anim_frame = frame_q;
    anim_busy  = (state_q == PLAY);
    anim_done  = (state_q == DONE);
    anim_state = state_q;
  end

endmodule

// File: rtl/sprite_anim_renderer.sv
// Animated, scaled, flippable sprite renderer driving an external synchronous
// ROM; emits palette index + hit three cycles after the pixel coordinates.
module sprite_anim_renderer
  import sprite_pkg::*;
#(
  parameter int SPRITE_W   = 64,
  parameter int SPRITE_H   = 64,
  parameter int FRAMES     = 4,
  parameter int IDX_W      = 4,
  parameter int SCALE_SH   = 1,
  parameter int HOLD_TICKS = 8,
  parameter int TRANSP_IDX = 0,
  localparam int ADDR_W    = $clog2(SPRITE_W * SPRITE_H * FRAMES),
  localparam int FR_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               anim_start,
  input  logic               anim_mode,
  input  logic               flip_x,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               blank,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pix_idx,
  output logic               pix_hit,
  output logic [FR_W-1:0]    anim_frame,
  output logic               anim_busy,
  output logic               anim_done,
  output logic [1:0]         anim_state
);

  localparam int LX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int LY_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [COORD_W:0] BOX_W = (COORD_W + 1)'(SPRITE_W << SCALE_SH);
  localparam logic [COORD_W:0] BOX_H = (COORD_W + 1)'(SPRITE_H << SCALE_SH);

  logic [COORD_W:0] dx, dy;
  logic             in_box;
  logic [LX_W-1:0]  lx_raw, lx;
  logic [LY_W-1:0]  ly;
  logic [ADDR_W-1:0] addr_d;
  logic             opaque;
  logic             v1, v2;

  sprite_anim_seq #(
    .FRAMES     (FRAMES),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_seq (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .anim_start  (anim_start),
    .anim_mode   (anim_mode),
    .anim_frame  (anim_frame),
    .anim_busy   (anim_busy),
    .anim_done   (anim_done),
    .anim_state  (anim_state)
  );

  // The extra MSB of dx/dy is the borrow: set when the pixel lies left/above.
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, sprite_x};
    dy     = {1'b0, DrawY} - {1'b0, sprite_y};
    in_box = ~dx[COORD_W] & ~dy[COORD_W] & (dx < BOX_W) & (dy < BOX_H);
    lx_raw = LX_W'(dx >> SCALE_SH);
    ly     = LY_W'(dy >> SCALE_SH);
    lx     = flip_x ? (LX_W'(SPRITE_W - 1) - lx_raw) : lx_raw;
    addr_d = ADDR_W'(anim_frame) * ADDR_W'(SPRITE_W * SPRITE_H)
           + ADDR_W'(ly) * ADDR_W'(SPRITE_W)
           + ADDR_W'(lx);
    opaque = (rom_q != IDX_W'(TRANSP_IDX));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      pix_hit     <= 1'b0;
      pix_idx     <= '0;
    end else begin
      if (in_box) rom_address <= addr_d;
      v1      <= in_box & blank;
      v2      <= v1;
      pix_hit <= v2 & opaque;
      pix_idx <= (v2 && opaque) ? rom_q : '0;
    end
  end

endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
Parametrised successor to the single-image full-screen sprite example. It renders one animated sprite sheet (FRAMES frames of SPRITE_W x SPRITE_H palette indices) at a programmable screen position, with integer power-of-two scaling, horizontal flip, a transparent colour key and a loop/one-shot animation sequencer. It drives an external synchronous sprite ROM. It outputs a per-pixel palette index plus a hit flag, pipeline-aligned for the downstream compositor/palette stage.

Parameters:
SPRITE_W, 64, sprite width in texels
SPRITE_H, 64, sprite height in texels
FRAMES, 4, frames stacked in ROM; frame f occupies words f*W*H .. (f+1)*W*H-1
IDX_W, 4, palette index width
SCALE_SH, 1, on-screen scale = 2**SCALE_SH per axis
HOLD_TICKS, 8, video frames each animation frame is held (>=1)
TRANSP_IDX, 0, palette index treated as transparent
ADDR_W, $clog2(SPRITE_W*SPRITE_H*FRAMES), derived localparam; not overridable

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse per video frame (start of vblank)
anim_start  in  1  one-cycle pulse: (re)start animation at frame 0
anim_mode  in  1  0 = loop, 1 = one-shot (hold last frame); sampled on anim_start
flip_x  in  1  mirror horizontally; sampled per pixel
sprite_x  in  10  top-left X on screen
sprite_y  in  10  top-left Y on screen
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
blank  in  1  1 = active video
rom_address  out  ADDR_W  registered ROM address
rom_q  in  IDX_W  ROM data, valid one cycle after rom_address
pix_idx  out  IDX_W  palette index (0 when pix_hit=0)
pix_hit  out  1  opaque sprite pixel at the aligned position
anim_frame  out  $clog2(FRAMES)  current animation frame
anim_busy  out  1  1 in PLAY
anim_done  out  1  1 in DONE (one-shot finished)

Behaviour:
- Reset: rom_address=0, pix_idx=0, pix_hit=0, anim_frame=0, anim_busy=0, anim_done=0, FSM=IDLE, tick counter=0, pipeline valids cleared. Reset mid-line drops in-flight pixels; no hit is emitted until 3 cycles after release.
- Pipeline, inputs sampled at edge k:
 - S1 (edge k+1): dx=DrawX-sprite_x, dy=DrawY-sprite_y in 11-bit arithmetic. in_box = no borrow AND dx < SPRITE_W<<SCALE_SH AND dy < SPRITE_H<<SCALE_SH. lx=dx>>SCALE_SH, ly=dy>>SCALE_SH. If flip_x, lx=SPRITE_W-1-lx. rom_address = anim_frame*W*H + ly*W + lx when in_box, else held. Register in_box&blank as v1.
 - S2 (edge k+2): ROM returns rom_q. v2<=v1.
 - S3 (edge k+3): pix_hit = v2 & (rom_q != TRANSP_IDX). pix_idx = pix_hit ? rom_q : 0.
 - Total latency 3 cycles. Throughput 1 pixel/cycle, no stalls.
- Sprite partly off-screen: no wrap. Only the on-screen texels appear, since DrawX/DrawY never exceed the visible range. sprite_x beyond 639 gives no hits.
- anim_frame is sampled in S1; a frame change mid-line takes effect from the next pixel (normally only at vblank).
- Animation FSM:
 - IDLE: anim_frame=0, counter=0. anim_start -> PLAY.
 - PLAY: anim_busy=1. On each frame_start the counter increments. When the counter reaches HOLD_TICKS-1 with a frame_start, the counter goes to 0 and the frame advances.
 - At frame FRAMES-1 advance: loop mode wraps to 0 and stays in PLAY; one-shot mode goes to DONE with anim_frame=FRAMES-1.
 - DONE: anim_done=1, frame held, frame_start ignored. anim_start -> PLAY.
- anim_start in any state: anim_frame=0, counter=0, mode latched, go to PLAY next cycle. It wins over a simultaneous frame_start, which is not counted.
- FRAMES=1: PLAY holds frame 0. One-shot goes to DONE after HOLD_TICKS frame_starts.

Decomposition:
- Shared package sprite_pkg: anim_state_t enum (IDLE, PLAY, DONE), anim_mode_t (LOOP=0, ONESHOT=1), screen constants H_ACTIVE=640, V_ACTIVE=480, coordinate width 10.
- One sub-module, sprite_anim_seq: the FSM plus tick counter. Inputs frame_start, anim_start, anim_mode; outputs anim_frame, anim_busy, anim_done.
- Address/hit pipeline stays in the top module. ROM and palette are external.

Test Plan:
1. Defaults, sprite at (100,50), ROM texel(0,0)=5 frame 0, blank=1, DrawX/Y=(100,50) -> rom_address=0 at k+1, pix_idx=5, pix_hit=1 at k+3. DrawX=99 -> pix_hit=0.
2. Scale: DrawX=101,DrawY=51 -> address 0. DrawX=102 -> address 1. DrawX=227 -> address 63. DrawX=228 -> pix_hit=0. flip_x=1 at DrawX=100 -> address 63.
3. Transparency/blank: texel=0 -> pix_hit=0, pix_idx=0. texel=7 with blank=0 -> pix_hit=0.
4. Loop: anim_start, mode 0, 32 frame_starts -> anim_frame steps 1,2,3 after 8/16/24 and wraps to 0 at 32. Frame 2 address base=8192.
5. One-shot: 32 frame_starts -> anim_done=1, anim_frame=3, held through 10 more. anim_start coincident with frame_start -> frame 0, counter 0, PLAY.
6. Reset asserted mid-PLAY (frame 2) and mid-line -> all outputs 0 immediately (async). After release, IDLE. First hit no earlier than 3 cycles later.
